// File: rtl/regfile_mp_sb_pkg.sv
// Shared sizing constants for the multi-port register file with scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_mp_sb_pkg;

    // Data width of one architectural register.
    localparam int RF_XLEN   = 64;
    // Number of architectural registers, x0 included.
    localparam int RF_NREGS  = 32;
    // Register address width.
    localparam int RF_AW     = $clog2(RF_NREGS);
    // Width of the producer tag stored per register.
    localparam int RF_TAG_W  = 4;
    // Default read and write port counts.
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 2;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port select: same-cycle write data (youngest port wins), else stored value, x0 reads zero.
// Latency: purely combinational, zero cycles.
// Backpressure: none; also reports whether a tag-matching write retires the addressed register this cycle.
module regfile_bypass_mux
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int AW     = RF_AW,
    parameter int NUM_WR = RF_NUM_WR,
    parameter int TAG_W  = RF_TAG_W
) (
    input  logic [AW-1:0]           rd_addr_i,
    input  logic [NUM_WR-1:0]       wr_en_i,
    input  logic [NUM_WR*AW-1:0]    wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]  wr_data_i,
    input  logic [NUM_WR*TAG_W-1:0] wr_tag_i,
    input  logic [XLEN-1:0]         stored_data_i,
    input  logic [TAG_W-1:0]        stored_tag_i,
    output logic [XLEN-1:0]         rd_data_o,
    output logic                    clr_hit_o
);

    // Walk write ports oldest to youngest so the highest matching port overrides; x0 forces zero.
    always_comb begin
        rd_data_o = stored_data_i;
        clr_hit_o = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i)) begin
                rd_data_o = wr_data_i[w*XLEN +: XLEN];
                if (wr_tag_i[w*TAG_W +: TAG_W] == stored_tag_i) begin
                    clr_hit_o = 1'b1;
                end
            end
        end
        if (rd_addr_i == '0) begin
            rd_data_o = '0;
            clr_hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Integer register file with N read / M write ports, write-to-read bypass and a per-register busy/tag scoreboard.
// Latency: reads and busy lookups are combinational; writes, reserves and clears take effect at the next clock edge.
// Backpressure: none; every enabled write and reserve is accepted in the cycle it is presented.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR,
    parameter int TAG_W  = RF_TAG_W,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*XLEN-1:0]  rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*XLEN-1:0]  wr_data,
    input  logic [NUM_WR*TAG_W-1:0] wr_tag,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
    input  logic [TAG_W-1:0]        rsv_tag,
    input  logic                    flush
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [TAG_W-1:0] tag_q  [NREGS];
    logic [TAG_W-1:0] tag_d  [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Data update: later write ports overwrite earlier ones, x0 is never written.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            end
        end
    end

    // Scoreboard next state: flush beats reserve, reserve beats a tag-matching writeback clear.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (rsv_en && (rsv_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
                tag_d[r]  = rsv_tag;
            end else begin
                // A writeback retires the register only if it carries the latest producer tag.
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))
                        && (wr_tag[w*TAG_W +: TAG_W] == tag_q[r])) begin
                        busy_d[r] = 1'b0;
                    end
                end
            end
        end
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    // State registers; reset drops any in-flight write and clears the scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] rd_addr_p;
        logic          clr_hit;

        assign rd_addr_p = rd_addr[p*AW +: AW];

        regfile_bypass_mux #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NUM_WR (NUM_WR),
            .TAG_W  (TAG_W)
        ) u_mux (
            .rd_addr_i     (rd_addr_p),
            .wr_en_i       (wr_en),
            .wr_addr_i     (wr_addr),
            .wr_data_i     (wr_data),
            .wr_tag_i      (wr_tag),
            .stored_data_i (regs_q[rd_addr_p]),
            .stored_tag_i  (tag_q[rd_addr_p]),
            .rd_data_o     (rd_data[p*XLEN +: XLEN]),
            .clr_hit_o     (clr_hit)
        );

        // Busy as seen after this cycle's writebacks; busy_q[0] is always 0 so x0 never reads busy.
        assign rd_busy[p] = busy_q[rd_addr_p] & ~clr_hit;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and randomised checks of regfile_mp_sb in the default and a wide-port configuration.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Shared stimulus; configuration A sees ports 0..1 and the low 4 tag bits.
    logic [4:0]  ra [4];
    logic [2:0]  wen;
    logic [4:0]  wa [3];
    logic [63:0] wd [3];
    logic [5:0]  wt [3];
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [5:0]  rsv_tag;
    logic        flush;

    logic [9:0]   rd_addr_a;
    logic [127:0] rd_data_a;
    logic [1:0]   rd_busy_a;
    logic [9:0]   wr_addr_a;
    logic [127:0] wr_data_a;
    logic [7:0]   wr_tag_a;

    logic [19:0]  rd_addr_b;
    logic [255:0] rd_data_b;
    logic [3:0]   rd_busy_b;
    logic [14:0]  wr_addr_b;
    logic [191:0] wr_data_b;
    logic [17:0]  wr_tag_b;

    assign rd_addr_a = {ra[1], ra[0]};
    assign wr_addr_a = {wa[1], wa[0]};
    assign wr_data_a = {wd[1], wd[0]};
    assign wr_tag_a  = {wt[1][3:0], wt[0][3:0]};
    assign rd_addr_b = {ra[3], ra[2], ra[1], ra[0]};
    assign wr_addr_b = {wa[2], wa[1], wa[0]};
    assign wr_data_b = {wd[2], wd[1], wd[0]};
    assign wr_tag_b  = {wt[2], wt[1], wt[0]};

    regfile_mp_sb dut_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr_a),
        .rd_data  (rd_data_a),
        .rd_busy  (rd_busy_a),
        .wr_en    (wen[1:0]),
        .wr_addr  (wr_addr_a),
        .wr_data  (wr_data_a),
        .wr_tag   (wr_tag_a),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_tag  (rsv_tag[3:0]),
        .flush    (flush)
    );

    regfile_mp_sb #(.NUM_RD(4), .NUM_WR(3), .TAG_W(6)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b),
        .wr_en    (wen),
        .wr_addr  (wr_addr_b),
        .wr_data  (wr_data_b),
        .wr_tag   (wr_tag_b),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_tag  (rsv_tag),
        .flush    (flush)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference data contents of each configuration.
    logic [63:0] mdl_a [32];
    logic [63:0] mdl_b [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input int p, input logic [63:0] ea, input logic [63:0] eb,
                            input logic ba, input logic bb);
        if (p < 2) begin
            chk($sformatf("%s/a%0d.data", tag, p), rd_data_a[p*64 +: 64], ea);
            chk($sformatf("%s/a%0d.busy", tag, p), {63'b0, rd_busy_a[p]}, {63'b0, ba});
        end
        chk($sformatf("%s/b%0d.data", tag, p), rd_data_b[p*64 +: 64], eb);
        chk($sformatf("%s/b%0d.busy", tag, p), {63'b0, rd_busy_b[p]}, {63'b0, bb});
    endtask

    // Point every read port at one register and check data and busy on all of them.
    task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [63:0] ea,
                           input logic [63:0] eb, input logic ba, input logic bb);
        for (int p = 0; p < 4; p++) ra[p] = addr;
        #1;
        for (int p = 0; p < 4; p++) chk_port(tag, p, ea, eb, ba, bb);
    endtask

    task automatic idle();
        wen    = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    // Advance one clock edge, keeping the reference contents in step with the applied writes.
    task automatic tick();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                mdl_a[r] = '0;
                mdl_b[r] = '0;
            end
        end else begin
            for (int w = 0; w < 3; w++) begin
                if (wen[w] && wa[w] != 5'd0) begin
                    if (w < 2) mdl_a[wa[w]] = wd[w];
                    mdl_b[wa[w]] = wd[w];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int w, input logic [4:0] a, input logic [63:0] d, input logic [5:0] t);
        wen[w] = 1'b1;
        wa[w]  = a;
        wd[w]  = d;
        wt[w]  = t;
    endtask

    task automatic rsv(input logic [4:0] a, input logic [5:0] t);
        rsv_en   = 1'b1;
        rsv_addr = a;
        rsv_tag  = t;
    endtask

    function automatic logic [63:0] exp_rd(input int nw, input logic [4:0] a, input logic [63:0] stored);
        logic [63:0] v;
        v = stored;
        for (int w = 0; w < nw; w++) begin
            if (wen[w] && wa[w] == a) v = wd[w];
        end
        if (a == 5'd0) v = '0;
        return v;
    endfunction

    initial begin
        for (int p = 0; p < 4; p++) ra[p] = '0;
        for (int w = 0; w < 3; w++) begin
            wa[w] = '0;
            wd[w] = '0;
            wt[w] = '0;
        end
        rsv_addr = '0;
        rsv_tag  = '0;
        idle();

        // Reset state
        tick();
        tick();
        chk_reg("rst_x3", 5'd3, 64'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_reg("rst_rel_x31", 5'd31, 64'h0, 64'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-run clears data and busy immediately
        tick();
        wr(0, 5'd5, 64'h1234, 6'd0);
        rsv(5'd5, 6'd1);
        tick();
        idle();
        chk_reg("pre_rst_x5", 5'd5, 64'h1234, 64'h1234, 1'b1, 1'b1);
        rst = 1'b1;
        chk_reg("async_rst_x5", 5'd5, 64'h0, 64'h0, 1'b0, 1'b0);
        wr(0, 5'd6, 64'h66, 6'd0);
        tick();
        idle();
        rst = 1'b0;
        chk_reg("rst_drop_x6", 5'd6, 64'h0, 64'h0, 1'b0, 1'b0);

        // Write every register through port 0, then read back on all ports
        tick();
        for (int i = 1; i < 32; i++) begin
            wr(0, 5'(i), 64'(i) * 64'h0101010101010101, 6'd0);
            tick();
        end
        idle();
        for (int i = 1; i < 32; i++) begin
            chk_reg("wr_all", 5'(i), 64'(i) * 64'h0101010101010101,
                    64'(i) * 64'h0101010101010101, 1'b0, 1'b0);
        end
        tick();
        wr(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0);
        chk_reg("x0_bypass", 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
        tick();
        idle();
        chk_reg("x0_after", 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);

        // Bypass with same-address writes: youngest port wins
        wr(0, 5'd7, 64'hAAAA, 6'd0);
        wr(1, 5'd7, 64'hBBBB, 6'd0);
        chk_reg("byp_x7", 5'd7, 64'hBBBB, 64'hBBBB, 1'b0, 1'b0);
        tick();
        idle();
        chk_reg("stored_x7", 5'd7, 64'hBBBB, 64'hBBBB, 1'b0, 1'b0);
        wr(0, 5'd8, 64'h1, 6'd0);
        wr(1, 5'd8, 64'h2, 6'd0);
        wr(2, 5'd8, 64'h3, 6'd0);
        chk_reg("byp3_x8", 5'd8, 64'h2, 64'h3, 1'b0, 1'b0);
        tick();
        idle();
        chk_reg("stored3_x8", 5'd8, 64'h2, 64'h3, 1'b0, 1'b0);

        // Stale tag updates data but keeps busy; matching tag clears in the same cycle
        rsv(5'd9, 6'd3);
        tick();
        idle();
        chk_reg("rsv_x9", 5'd9, 64'h0909090909090909, 64'h0909090909090909, 1'b1, 1'b1);
        wr(1, 5'd9, 64'h99, 6'd2);
        chk_reg("stale_x9_now", 5'd9, 64'h99, 64'h99, 1'b1, 1'b1);
        tick();
        idle();
        chk_reg("stale_x9", 5'd9, 64'h99, 64'h99, 1'b1, 1'b1);
        wr(0, 5'd9, 64'h9A, 6'd3);
        chk_reg("match_x9_now", 5'd9, 64'h9A, 64'h9A, 1'b0, 1'b0);
        tick();
        idle();
        chk_reg("match_x9", 5'd9, 64'h9A, 64'h9A, 1'b0, 1'b0);

        // Full tag width matters: 0x03 matches the 4-bit tag 0x3 but not the 6-bit tag 0x23
        rsv(5'd10, 6'h23);
        tick();
        idle();
        wr(0, 5'd10, 64'h1, 6'h03);
        chk_reg("tagw_x10_now", 5'd10, 64'h1, 64'h1, 1'b0, 1'b1);
        tick();
        idle();
        chk_reg("tagw_x10", 5'd10, 64'h1, 64'h1, 1'b0, 1'b1);
        wr(2, 5'd10, 64'h2, 6'h23);
        chk_reg("p2_x10_now", 5'd10, 64'h1, 64'h2, 1'b0, 1'b0);
        tick();
        idle();
        chk_reg("p2_x10", 5'd10, 64'h1, 64'h2, 1'b0, 1'b0);

        // Re-reserving a busy register retires the older producer's tag
        rsv(5'd4, 6'd1);
        tick();
        rsv(5'd4, 6'd5);
        tick();
        idle();
        chk_reg("rerv_x4", 5'd4, 64'h0404040404040404, 64'h0404040404040404, 1'b1, 1'b1);
        wr(0, 5'd4, 64'h41, 6'd1);
        chk_reg("old_x4_now", 5'd4, 64'h41, 64'h41, 1'b1, 1'b1);
        tick();
        idle();
        chk_reg("old_x4", 5'd4, 64'h41, 64'h41, 1'b1, 1'b1);
        wr(1, 5'd4, 64'h45, 6'd5);
        chk_reg("new_x4_now", 5'd4, 64'h45, 64'h45, 1'b0, 1'b0);
        tick();
        idle();
        chk_reg("new_x4", 5'd4, 64'h45, 64'h45, 1'b0, 1'b0);

        // Reserve wins over a same-cycle matching writeback
        rsv(5'd4, 6'd6);
        wr(0, 5'd4, 64'h46, 6'd6);
        tick();
        idle();
        chk_reg("rsv_wins_x4", 5'd4, 64'h46, 64'h46, 1'b1, 1'b1);

        // Reserving x0 is ignored
        rsv(5'd0, 6'd7);
        tick();
        idle();
        chk_reg("rsv_x0", 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);

        // Flush clears every busy bit and discards a same-cycle reserve
        rsv(5'd12, 6'd2);
        tick();
        idle();
        chk_reg("rsv_x12", 5'd12, 64'h0C0C0C0C0C0C0C0C, 64'h0C0C0C0C0C0C0C0C, 1'b1, 1'b1);
        flush = 1'b1;
        rsv(5'd4, 6'd7);
        tick();
        idle();
        chk_reg("flush_x4", 5'd4, 64'h46, 64'h46, 1'b0, 1'b0);
        chk_reg("flush_x12", 5'd12, 64'h0C0C0C0C0C0C0C0C, 64'h0C0C0C0C0C0C0C0C, 1'b0, 1'b0);

        // Random writes with address collisions, bypass checked against the reference contents
        tick();
        for (int i = 0; i < 150; i++) begin
            wen = 3'($urandom_range(0, 7));
            for (int w = 0; w < 3; w++) begin
                wa[w] = 5'($urandom_range(0, 7));
                wd[w] = {$urandom, $urandom};
                wt[w] = 6'($urandom_range(0, 63));
            end
            for (int p = 0; p < 4; p++) ra[p] = 5'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < 4; p++) begin
                chk_port("rand", p, exp_rd(2, ra[p], mdl_a[ra[p]]),
                         exp_rd(3, ra[p], mdl_b[ra[p]]), 1'b0, 1'b0);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            chk_reg("final", 5'(i), mdl_a[i], mdl_b[i], 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
